// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store initiator: forms rs_data+constant, drives a req/ack RAM handshake,
// stalls EX until the RAM answers or the wait budget runs out, and returns load data to write-back.
module mem_stage_lsu #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 5,
    parameter int MEM_DEPTH = 31,
    parameter int TIMEOUT   = 15,
    parameter int OP_LOAD   = 7,
    parameter int OP_STORE  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [5:0]        constant,
    input  logic [DATA_W-1:0] rd_load,
    input  logic [2:0]        rd_sel,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        wb_sel,
    output logic              addr_err,
    output logic              timeout_err
);

    localparam int SUM_W = DATA_W + 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [2:0]         sel_q;
    logic [SUM_W-1:0]   sum;
    logic               in_range;
    logic               start;
    logic               last_wait;
    logic               issue;
    logic               drop;
    logic               done_ack;
    logic               done_timeout;

    // The extra sum bit keeps a carry out of rs_data from wrapping into a legal address.
    assign sum       = {1'b0, rs_data} + SUM_W'(constant);
    assign in_range  = sum < SUM_W'(MEM_DEPTH);
    assign start     = op_valid && (opcode == 4'(OP_LOAD) || opcode == 4'(OP_STORE));
    assign last_wait = wait_cnt == CNT_W'(TIMEOUT - 1);

    // Handshake: mem_req rises on the issue edge and stays high with mem_we/mem_addr/mem_wdata
    // frozen; a one-cycle mem_ack seen in WAIT completes the access and mem_req falls on the
    // next edge. EX holds its op while stall=1 and advances on the first edge with stall=0.
    always_comb begin
        next_state   = state;
        stall        = 1'b0;
        issue        = 1'b0;
        drop         = 1'b0;
        done_ack     = 1'b0;
        done_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (in_range) begin
                        stall      = 1'b1;
                        issue      = 1'b1;
                        next_state = S_WAIT;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    done_ack   = 1'b1;
                    next_state = S_IDLE;
                end else if (last_wait) begin
                    done_timeout = 1'b1;
                    next_state   = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_sel      <= '0;
            addr_err    <= 1'b0;
            timeout_err <= 1'b0;
            sel_q       <= '0;
            wait_cnt    <= '0;
        end else begin
            wb_valid    <= 1'b0;
            addr_err    <= 1'b0;
            timeout_err <= 1'b0;
            if (issue) begin
                mem_req   <= 1'b1;
                mem_we    <= (opcode == 4'(OP_STORE));
                mem_addr  <= sum[ADDR_W-1:0];
                mem_wdata <= rd_load;
                sel_q     <= rd_sel;
                wait_cnt  <= '0;
            end
            if (drop) begin
                addr_err <= 1'b1;
            end
            if (done_ack) begin
                mem_req <= 1'b0;
                if (!mem_we) begin
                    wb_valid <= 1'b1;
                    wb_data  <= mem_rdata;
                    wb_sel   <= sel_q;
                end
            end
            if (done_timeout) begin
                mem_req     <= 1'b0;
                timeout_err <= 1'b1;
            end
            if (state == S_WAIT && !done_ack && !done_timeout) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus randomized ops; an event scoreboard is filled
// at issue time from address arithmetic and a planned RAM response, and a monitor drains it.
module tb_mem_stage_lsu;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 31;
    localparam int TMO    = 15;
    localparam int EW     = 28;

    localparam logic [2:0] K_REQ  = 3'd1;
    localparam logic [2:0] K_WB   = 3'd2;
    localparam logic [2:0] K_AERR = 3'd3;
    localparam logic [2:0] K_TERR = 3'd4;

    logic              clk;
    logic              rst_n;
    logic              op_valid;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] rs_data;
    logic [5:0]        constant;
    logic [DATA_W-1:0] rd_load;
    logic [2:0]        rd_sel;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [4:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [2:0]        wb_sel;
    logic              addr_err;
    logic              timeout_err;

    logic [EW-1:0]     exp_q[$];
    int                plan_k_q[$];
    logic [15:0]       plan_d_q[$];
    int                total = 0;
    int                bad = 0;
    bit                resp_en = 1'b1;
    bit                man_ack = 1'b0;

    mem_stage_lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .opcode      (opcode),
        .rs_data     (rs_data),
        .constant    (constant),
        .rd_load     (rd_load),
        .rd_sel      (rd_sel),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_sel      (wb_sel),
        .addr_err    (addr_err),
        .timeout_err (timeout_err)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [EW-1:0] ev(input logic [2:0] kind, input logic we,
                                         input logic [4:0] addr, input logic [15:0] data,
                                         input logic [2:0] sel);
        return {kind, we, addr, data, sel};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [EW-1:0] got);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got=%0h exp=none (unexpected event) at %0t", name, got, $time);
        end else begin
            check(name, 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    // RAM responder: acks in the planned WAIT cycle (k), never if k is beyond the budget;
    // stray acks while no request is outstanding must be ignored by the DUT.
    initial begin
        int wait_cnt;
        int cur_k;
        logic [15:0] cur_d;
        wait_cnt  = 0;
        cur_k     = 0;
        cur_d     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                mem_ack   = man_ack;
                mem_rdata = 16'hDEAD;
                wait_cnt  = 0;
            end else if (mem_req) begin
                wait_cnt++;
                if (wait_cnt == 1) begin
                    if (plan_k_q.size() > 0) begin
                        cur_k = plan_k_q.pop_front();
                        cur_d = plan_d_q.pop_front();
                    end else begin
                        cur_k = 0;
                    end
                end
                mem_ack   = (wait_cnt == cur_k);
                mem_rdata = mem_ack ? cur_d : 16'($urandom);
            end else begin
                wait_cnt  = 0;
                mem_ack   = ($urandom_range(0, 7) == 0);
                mem_rdata = 16'($urandom);
            end
        end
    end

    // monitor: every observable event pops the scoreboard; request fields checked while held
    initial begin
        bit prev_req;
        logic [21:0] held;
        prev_req = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (wb_valid) pop_cmp("wb", ev(K_WB, 1'b0, 5'd0, wb_data, wb_sel));
                if (addr_err) pop_cmp("addr_err", ev(K_AERR, 1'b0, 5'd0, 16'd0, 3'd0));
                if (timeout_err) pop_cmp("timeout", ev(K_TERR, 1'b0, 5'd0, 16'd0, 3'd0));
                if (mem_req && !prev_req) begin
                    pop_cmp("req", ev(K_REQ, mem_we, mem_addr, mem_wdata, 3'd0));
                    held = {mem_we, mem_addr, mem_wdata};
                end else if (mem_req) begin
                    check("req_hold", 32'({mem_we, mem_addr, mem_wdata}), 32'(held));
                end
                prev_req = mem_req;
            end
        end
    end

    // driver: present one op, hold it while stall=1, predict every event it should cause
    task automatic issue(input logic [3:0] opc, input logic [15:0] rs, input logic [5:0] c,
                         input logic [15:0] rd, input logic [2:0] sel, input int k,
                         input logic [15:0] rdata);
        int  sum;
        int  exp_stall;
        int  stalls;
        bit  done;
        sum       = int'(rs) + int'(c);
        exp_stall = 0;
        if (opc == 4'd7 || opc == 4'd8) begin
            if (sum >= DEPTH) begin
                exp_q.push_back(ev(K_AERR, 1'b0, 5'd0, 16'd0, 3'd0));
            end else begin
                exp_q.push_back(ev(K_REQ, opc == 4'd8, sum[4:0], rd, 3'd0));
                plan_k_q.push_back(k);
                plan_d_q.push_back(rdata);
                if (k >= 1 && k <= TMO) begin
                    exp_stall = k;
                    if (opc == 4'd7) exp_q.push_back(ev(K_WB, 1'b0, 5'd0, rdata, sel));
                end else begin
                    exp_stall = TMO;
                    exp_q.push_back(ev(K_TERR, 1'b0, 5'd0, 16'd0, 3'd0));
                end
            end
        end
        op_valid = 1'b1;
        opcode   = opc;
        rs_data  = rs;
        constant = c;
        rd_load  = rd;
        rd_sel   = sel;
        stalls   = 0;
        done     = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("stall_bound", 32'(done), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        op_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            op_valid = 1'b0;
            opcode   = 4'd7;
            @(negedge clk);
            check("idle_stall", 32'(stall), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0]  opc;
        logic [15:0] rs;
        logic [5:0]  c;
        int          r;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        opcode   = 4'd0;
        rs_data  = '0;
        constant = '0;
        rd_load  = '0;
        rd_sel   = '0;
        #3;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wb", 32'({wb_valid, wb_data, wb_sel}), 32'd0);
        check("rst_errs", 32'({addr_err, timeout_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed: load, slow store, out-of-range pair, timeout, back-to-back trio
        issue(4'd7, 16'd2, 6'd3, 16'h0000, 3'd6, 1, 16'h0002);
        idle(1);
        issue(4'd8, 16'd10, 6'd4, 16'hBEEF, 3'd1, 4, 16'h0000);
        idle(1);
        issue(4'd7, 16'd30, 6'd1, 16'h1111, 3'd2, 1, 16'h5555);
        issue(4'd7, 16'hFFFF, 6'd1, 16'h2222, 3'd3, 1, 16'h6666);
        idle(1);
        issue(4'd7, 16'd0, 6'd0, 16'h3333, 3'd4, 0, 16'h7777);
        idle(1);
        issue(4'd7, 16'd20, 6'd10, 16'h4444, 3'd5, 15, 16'hA5A5);
        issue(4'd7, 16'd1, 6'd1, 16'h0101, 3'd7, 1, 16'hC0DE);
        issue(4'd8, 16'd3, 6'd3, 16'hCAFE, 3'd0, 1, 16'h0000);
        issue(4'd3, 16'd4, 6'd4, 16'h0BAD, 3'd1, 1, 16'h0000);
        idle(2);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4) opc = 4'd7;
            else if (r < 8) opc = 4'd8;
            else begin
                opc = 4'($urandom_range(0, 15));
                if (opc == 4'd7 || opc == 4'd8) opc = 4'd3;
            end
            rs = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 30));
            c  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
            issue(opc, rs, c, 16'($urandom), 3'($urandom_range(0, 7)), $urandom_range(1, 17),
                  16'($urandom));
            idle($urandom_range(0, 2));
        end
        idle(3);

        // reset in the second WAIT cycle, then a stale ack that must be ignored
        resp_en  = 1'b0;
        man_ack  = 1'b0;
        op_valid = 1'b1;
        opcode   = 4'd7;
        rs_data  = 16'd4;
        constant = 6'd1;
        rd_load  = 16'h1234;
        rd_sel   = 3'd5;
        exp_q.push_back(ev(K_REQ, 1'b0, 5'd5, 16'h1234, 3'd0));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check("rst_pre_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        check("rst_pre_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_req", 32'(mem_req), 32'd0);
        check("async_stall", 32'(stall), 32'd0);
        check("async_pulses", 32'({wb_valid, timeout_err, addr_err}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stale_ack", 32'({mem_req, wb_valid, timeout_err, stall}), 32'd0);
        end
        resp_en = 1'b1;
        idle(2);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
